// File: rtl/tbuf_bus_arbiter_if.sv
// Bus bundle between the TBUF requesters and the round-robin arbiter:
// level requests in, one-hot driver enables and pad/status flags out.
interface tbuf_bus_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  REQ;
    logic [N-1:0]  GNT;
    logic          OEN;
    logic [IW-1:0] OWNER;
    logic          BUSY;
    logic          TURN;

    modport master (output REQ, input GNT, OEN, OWNER, BUSY, TURN);
    modport slave  (input REQ, output GNT, OEN, OWNER, BUSY, TURN);
endinterface

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state net with guaranteed
// all-off turnaround between owners; every output comes straight from a flop.
module tbuf_bus_arbiter #(
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(N)
) (
    input  logic                  CK,
    input  logic                  RST,
    tbuf_bus_arbiter_if.slave     bus
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic          r_oen;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_turn, w_turn_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [IW:0]   w_idx;
    logic [N-1:0]  w_owner_oh;
    logic          w_others;
    logic          w_arb;

    // Scan from the priority pointer upward, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + (IW + 1)'(i);
            if (w_idx >= N_EXT) w_idx = w_idx - N_EXT;
            if (!w_found && bus.REQ[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_owner_oh = N'(1) << r_owner;
    assign w_others   = |(bus.REQ & ~w_owner_oh);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_turn_nxt  = r_turn;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_tcnt_nxt  = r_tcnt;
        w_arb       = 1'b0;
        case (r_state)
            S_IDLE: w_arb = 1'b1;
            S_GRANT: begin
                if (!bus.REQ[r_owner] ||
                    (MAX_HOLD != 0 && r_hold == HOLD_LIM && w_others)) begin
                    w_state_nxt = S_TURN;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_turn_nxt  = 1'b1;
                    w_tcnt_nxt  = TW'(1);
                    w_ptr_nxt   = (r_owner == LAST_IDX) ? '0 : r_owner + IW'(1);
                end else if (MAX_HOLD != 0 && r_hold != HOLD_LIM) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            S_TURN: begin
                if (r_tcnt == TURN_LIM) begin
                    w_state_nxt = S_IDLE;
                    w_turn_nxt  = 1'b0;
                    w_arb       = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_arb && w_found) begin
            w_state_nxt = S_GRANT;
            w_gnt_nxt   = N'(1) << w_win;
            w_owner_nxt = w_win;
            w_busy_nxt  = 1'b1;
            w_hold_nxt  = HW'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_oen   <= 1'b1;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_turn  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_oen   <= ~|w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_turn  <= w_turn_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign bus.GNT   = r_gnt;
    assign bus.OEN   = r_oen;
    assign bus.OWNER = r_owner;
    assign bus.BUSY  = r_busy;
    assign bus.TURN  = r_turn;

    // Requests must be known once out of reset; an X here is a bench bug.
    a_req_known: assert property (@(posedge CK) disable iff (RST) !$isunknown(bus.REQ));
    a_onehot: assert property (@(posedge CK) disable iff (RST) $onehot0(r_gnt));

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Bench for tbuf_bus_arbiter: three configurations checked every cycle against
// an owner/dead-cycle model, plus directed scenarios with literal expectations.
module tb_tbuf_bus_arbiter;

    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    tbuf_bus_arbiter_if #(.N(4)) bus_a ();
    tbuf_bus_arbiter_if #(.N(4)) bus_b ();
    tbuf_bus_arbiter_if #(.N(3)) bus_c ();

    tbuf_bus_arbiter #(.N(4), .TURN_CYC(1), .MAX_HOLD(8)) dut_a (.CK(CK), .RST(RST), .bus(bus_a));
    tbuf_bus_arbiter #(.N(4), .TURN_CYC(3), .MAX_HOLD(8)) dut_b (.CK(CK), .RST(RST), .bus(bus_b));
    tbuf_bus_arbiter #(.N(3), .TURN_CYC(1), .MAX_HOLD(2)) dut_c (.CK(CK), .RST(RST), .bus(bus_c));

    // owner = -1 when nobody holds the net; dead = turnaround cycles elapsed
    typedef struct packed {
        int owner;
        int held;
        int dead;
        int ptr;
    } mst_t;

    int   checks   = 0;
    int   failures = 0;
    mst_t ma, mb, mc;

    function automatic mst_t mreset();
        mst_t r;
        r.owner = -1;
        r.held  = 0;
        r.dead  = 0;
        r.ptr   = 0;
        return r;
    endfunction

    function automatic mst_t mstep(mst_t s, logic [15:0] req, int n, int tc, int mh);
        mst_t r;
        bit   others;
        int   c;
        r      = s;
        others = 1'b0;
        if (s.owner >= 0) begin
            for (int j = 0; j < n; j++)
                if (j != s.owner && req[j]) others = 1'b1;
            if (!req[s.owner] || (mh != 0 && s.held >= mh && others)) begin
                r.owner = -1;
                r.held  = 0;
                r.dead  = 1;
                r.ptr   = (s.owner + 1) % n;
            end else if (s.held < mh) begin
                r.held = s.held + 1;
            end
        end else if (s.dead > 0 && s.dead < tc) begin
            r.dead = s.dead + 1;
        end else begin
            r.dead = 0;
            for (int i = 0; i < n; i++) begin
                c = (s.ptr + i) % n;
                if (r.owner < 0 && req[c]) begin
                    r.owner = c;
                    r.held  = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input mst_t m, input logic [15:0] gnt, input logic oen,
                       input logic [3:0] owner, input logic busy, input logic turn);
        logic [15:0] eg;
        eg = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
        chk({nm, ".GNT"}, 32'(gnt), 32'(eg));
        chk({nm, ".OEN"}, 32'(oen), 32'(m.owner < 0));
        chk({nm, ".BUSY"}, 32'(busy), 32'(m.owner >= 0));
        chk({nm, ".TURN"}, 32'(turn), 32'(m.dead > 0));
        if (m.owner >= 0) chk({nm, ".OWNER"}, 32'(owner), 32'(m.owner));
    endtask

    // One clock: advance the model on the sampled inputs, then compare all DUTs.
    task automatic tick();
        mst_t na, nb, nc;
        na = mstep(ma, 16'(bus_a.REQ), 4, 1, 8);
        nb = mstep(mb, 16'(bus_b.REQ), 4, 3, 8);
        nc = mstep(mc, 16'(bus_c.REQ), 3, 1, 2);
        @(posedge CK);
        #1;
        if (RST) begin
            ma = mreset();
            mb = mreset();
            mc = mreset();
        end else begin
            ma = na;
            mb = nb;
            mc = nc;
        end
        cmp("A", ma, 16'(bus_a.GNT), bus_a.OEN, 4'(bus_a.OWNER), bus_a.BUSY, bus_a.TURN);
        cmp("B", mb, 16'(bus_b.GNT), bus_b.OEN, 4'(bus_b.OWNER), bus_b.BUSY, bus_b.TURN);
        cmp("C", mc, 16'(bus_c.GNT), bus_c.OEN, 4'(bus_c.OWNER), bus_c.BUSY, bus_c.TURN);
    endtask

    initial begin
        logic [31:0] exp;
        bit          found;
        RST       = 1'b1;
        bus_a.REQ = '0;
        bus_b.REQ = '0;
        bus_c.REQ = '0;
        ma = mreset();
        mb = mreset();
        mc = mreset();

        // Reset then a single request from requester 2
        tick();
        tick();
        chk("rst_gnt", 32'(bus_a.GNT), 32'd0);
        chk("rst_oen", 32'(bus_a.OEN), 32'd1);
        chk("rst_owner", 32'(bus_a.OWNER), 32'd0);
        chk("rst_busy", 32'(bus_a.BUSY), 32'd0);
        chk("rst_turn", 32'(bus_a.TURN), 32'd0);
        RST       = 1'b0;
        bus_a.REQ = 4'b0100;
        tick();
        chk("t1_gnt", 32'(bus_a.GNT), 32'd4);
        chk("t1_oen", 32'(bus_a.OEN), 32'd0);
        chk("t1_owner", 32'(bus_a.OWNER), 32'd2);
        repeat (4) tick();
        bus_a.REQ = 4'b0000;
        tick();
        chk("t1_rel_gnt", 32'(bus_a.GNT), 32'd0);
        chk("t1_rel_turn", 32'(bus_a.TURN), 32'd1);
        tick();
        chk("t1_idle_turn", 32'(bus_a.TURN), 32'd0);
        bus_a.REQ = 4'b1001;
        tick();
        chk("t1_ptr3_owner", 32'(bus_a.OWNER), 32'd3);

        // Round robin with all requesting: 8 grant cycles then 1 dead cycle each
        bus_a.REQ = 4'b0000;
        tick();
        bus_a.REQ = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            tick();
            exp = ((k % 9) < 8) ? (32'd1 << ((k / 9) % 4)) : 32'd0;
            chk("t2_rr_gnt", 32'(bus_a.GNT), exp);
        end

        // Lone requester is never preempted
        bus_a.REQ = 4'b0000;
        tick();
        bus_a.REQ = 4'b0001;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("t3_hold_gnt", 32'(bus_a.GNT), 32'd1);
            chk("t3_hold_turn", 32'(bus_a.TURN), 32'd0);
        end
        bus_a.REQ = 4'b0011;
        tick();
        chk("t3_preempt_gnt", 32'(bus_a.GNT), 32'd0);
        chk("t3_preempt_turn", 32'(bus_a.TURN), 32'd1);
        tick();
        chk("t3_next_gnt", 32'(bus_a.GNT), 32'd2);

        // Reset while requester 3 owns the net
        bus_a.REQ = 4'b1111;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (bus_a.GNT == 4'b1000) found = 1'b1;
        end
        chk("t5_reach_owner3", 32'(found), 32'd1);
        RST = 1'b1;
        tick();
        chk("t5_rst_gnt", 32'(bus_a.GNT), 32'd0);
        chk("t5_rst_oen", 32'(bus_a.OEN), 32'd1);
        chk("t5_rst_busy", 32'(bus_a.BUSY), 32'd0);
        chk("t5_rst_turn", 32'(bus_a.TURN), 32'd0);
        RST = 1'b0;
        tick();
        chk("t5_first_gnt", 32'(bus_a.GNT), 32'd1);
        chk("t5_first_owner", 32'(bus_a.OWNER), 32'd0);

        // Three-cycle turnaround and re-grant to the same requester
        bus_b.REQ = 4'b0010;
        tick();
        chk("t4_gnt", 32'(bus_b.GNT), 32'd2);
        repeat (2) tick();
        bus_b.REQ = 4'b0000;
        tick();
        chk("t4_dead1_gnt", 32'(bus_b.GNT), 32'd0);
        bus_b.REQ = 4'b0010;
        tick();
        chk("t4_dead2_gnt", 32'(bus_b.GNT), 32'd0);
        chk("t4_dead2_turn", 32'(bus_b.TURN), 32'd1);
        tick();
        chk("t4_dead3_gnt", 32'(bus_b.GNT), 32'd0);
        chk("t4_dead3_oen", 32'(bus_b.OEN), 32'd1);
        tick();
        chk("t4_regrant_gnt", 32'(bus_b.GNT), 32'd2);

        // N=3 wrap with release coinciding with the hold limit
        bus_c.REQ = 3'b100;
        tick();
        chk("t6_gnt2", 32'(bus_c.GNT), 32'd4);
        bus_c.REQ = 3'b111;
        tick();
        chk("t6_hold_gnt2", 32'(bus_c.GNT), 32'd4);
        bus_c.REQ = 3'b011;
        tick();
        chk("t6_rel_gnt", 32'(bus_c.GNT), 32'd0);
        chk("t6_rel_turn", 32'(bus_c.TURN), 32'd1);
        bus_c.REQ = 3'b111;
        tick();
        chk("t6_wrap_gnt", 32'(bus_c.GNT), 32'd1);
        chk("t6_wrap_owner", 32'(bus_c.OWNER), 32'd0);
        chk("t6_wrap_turn", 32'(bus_c.TURN), 32'd0);

        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) bus_a.REQ = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus_b.REQ = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus_c.REQ = 3'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
